// File: rtl/dz_pkg.sv
// Shared definitions for the dot-matrix countdown display: matrix size,
// colour encodings and the 8x8 digit glyph table.
package dz_pkg;

  localparam int DZ_ROWS = 8;
  localparam int DZ_COLS = 8;

  typedef enum logic [1:0] {
    COL_OFF = 2'b00,
    COL_RED = 2'b01,
    COL_GRN = 2'b10,
    COL_YEL = 2'b11
  } dz_colour_e;

  localparam logic [DZ_COLS-1:0] DZ_BLANK = 8'h00;

  // One 64-bit word per digit; row 0 (top) in bits [63:56], row 7 in [7:0].
  localparam logic [63:0] DZ_GLYPH [10] = '{
    64'h3C666E7666663C00,  // 0
    64'h1838181818187E00,  // 1
    64'h3C66060C30607E00,  // 2
    64'h3C66061C06663C00,  // 3
    64'h0C1C3C6C7E0C0C00,  // 4
    64'h7E607C0606663C00,  // 5
    64'h3C607C6666663C00,  // 6
    64'h7E060C1830303000,  // 7
    64'h3C66663C66663C00,  // 8
    64'h3C66663E060C3800   // 9
  };

endpackage

// File: rtl/dz_font_rom.sv
// Combinational glyph lookup: (digit, row) -> 8-bit column pattern.
// Digits above 9 render blank.
module dz_font_rom
  import dz_pkg::*;
(
  input  logic [3:0]         i_digit,
  input  logic [2:0]         i_row,
  output logic [DZ_COLS-1:0] o_pat
);

  // Row r lives at bit offset (7-r)*8, and ~r == 7-r for a 3-bit row.
  logic [5:0] w_base;
  assign w_base = {~i_row, 3'b000};

  // Select the glyph slice, defaulting to blank for non-digits.
  always_comb begin
    o_pat = DZ_BLANK;
    if (i_digit <= 4'd9) begin
      o_pat = DZ_GLYPH[i_digit][w_base +: 8];
    end
  end

endmodule

// File: rtl/dz_scan_driver.sv
// Row-scanning driver for the 8x8 bicolour countdown matrix.
// New digit/colour values are captured into a shadow register and moved to
// the active register only at a frame boundary, so a frame never mixes glyphs.
// Optional feature: define DZ_SCAN_BLINK_EN to blink digit 0 every
// BLINK_FRAMES frames (rows keep scanning while columns are forced off).
module dz_scan_driver
  import dz_pkg::*;
#(
  parameter int SCAN_DIV     = 125
`ifdef DZ_SCAN_BLINK_EN
  ,
  parameter int BLINK_FRAMES = 32
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         digit_in,
  input  logic [1:0]         colour_in,
  input  logic               digit_vld,
  output logic [DZ_ROWS-1:0] row,
  output logic [DZ_COLS-1:0] colr,
  output logic [DZ_COLS-1:0] colg,
  output logic               frame_start
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [DIV_W-1:0]   r_div_cnt;
  logic [2:0]         r_row_idx;
  logic               r_run;
  logic [3:0]         r_shd_digit;
  logic [3:0]         r_act_digit;
  dz_colour_e         r_shd_col;
  dz_colour_e         r_act_col;

  logic               w_tick;
  logic               w_frame_end;
  logic               w_wrap;
  logic [2:0]         w_row_next;
  logic [3:0]         w_act_digit_next;
  dz_colour_e         w_act_col_next;
  logic [DZ_COLS-1:0] w_pat;
  logic               w_blank;

  assign w_tick = (r_div_cnt == DIV_W'(SCAN_DIV - 1));
  // Genuine 7->0 wrap of a running scan.
  assign w_wrap = w_tick && r_run && (r_row_idx == 3'd7);
  // The first tick after reset starts the scan at row 0 and counts as a
  // frame boundary too, so the first driven row is the top one.
  assign w_frame_end = w_tick && (!r_run || (r_row_idx == 3'd7));

  // Next row index and next active digit/colour (bypass on a coincident strobe).
  always_comb begin
    w_row_next       = r_row_idx;
    w_act_digit_next = r_act_digit;
    w_act_col_next   = r_act_col;
    if (w_tick) begin
      w_row_next = r_run ? (r_row_idx + 3'd1) : 3'd0;
    end
    if (w_frame_end) begin
      w_act_digit_next = digit_vld ? digit_in : r_shd_digit;
      w_act_col_next   = digit_vld ? dz_colour_e'(colour_in) : r_shd_col;
    end
  end

  dz_font_rom u_font (
    .i_digit (w_act_digit_next),
    .i_row   (w_row_next),
    .o_pat   (w_pat)
  );

`ifdef DZ_SCAN_BLINK_EN
  localparam int FCNT_W = (2 * BLINK_FRAMES > 1) ? $clog2(2 * BLINK_FRAMES) : 1;

  logic [FCNT_W-1:0] r_fcnt;
  logic [FCNT_W-1:0] w_fcnt_next;

  // Frame counter value that applies to the frame being entered.
  always_comb begin
    w_fcnt_next = r_fcnt;
    if (w_wrap) begin
      w_fcnt_next = (r_fcnt == FCNT_W'(2 * BLINK_FRAMES - 1)) ? '0 : (r_fcnt + 1'b1);
    end
  end

  // Count frame wraps modulo 2*BLINK_FRAMES.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_fcnt <= '0;
    else      r_fcnt <= w_fcnt_next;
  end

  assign w_blank = (w_act_digit_next == 4'd0) && (w_fcnt_next >= FCNT_W'(BLINK_FRAMES));
`else
  assign w_blank = 1'b0;
`endif

  // Row-period divider.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_div_cnt <= '0;
    else if (w_tick) r_div_cnt <= '0;
    else             r_div_cnt <= r_div_cnt + 1'b1;
  end

  // Row index and scan-started flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_row_idx <= 3'd0;
      r_run     <= 1'b0;
    end else if (w_tick) begin
      r_row_idx <= w_row_next;
      r_run     <= 1'b1;
    end
  end

  // Shadow capture: last strobe wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shd_digit <= 4'd0;
      r_shd_col   <= COL_OFF;
    end else if (digit_vld) begin
      r_shd_digit <= digit_in;
      r_shd_col   <= dz_colour_e'(colour_in);
    end
  end

  // Active digit/colour, refreshed only at frame boundaries.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_act_digit <= 4'd0;
      r_act_col   <= COL_OFF;
    end else begin
      r_act_digit <= w_act_digit_next;
      r_act_col   <= w_act_col_next;
    end
  end

  // Registered pin drive, updated once per row.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row         <= '1;
      colr        <= DZ_BLANK;
      colg        <= DZ_BLANK;
      frame_start <= 1'b0;
    end else begin
      frame_start <= w_frame_end;
      if (w_tick) begin
        row  <= ~(DZ_ROWS'(1) << w_row_next);
        colr <= (w_act_col_next[0] && !w_blank) ? w_pat : DZ_BLANK;
        colg <= (w_act_col_next[1] && !w_blank) ? w_pat : DZ_BLANK;
      end
    end
  end

endmodule

// File: tb/tb_dz_scan_driver.sv
// Directed bench for dz_scan_driver with SCAN_DIV=4 (and BLINK_FRAMES=2
// when DZ_SCAN_BLINK_EN is defined).
module tb_dz_scan_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] digit_in = 4'd0;
  logic [1:0] colour_in = 2'b00;
  logic       digit_vld = 1'b0;
  logic [7:0] row, colr, colg;
  logic       frame_start;

  int checks = 0;
  int failures = 0;
  bit blink_en;

  dz_scan_driver #(
    .SCAN_DIV(4)
`ifdef DZ_SCAN_BLINK_EN
    , .BLINK_FRAMES(2)
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .digit_in    (digit_in),
    .colour_in   (colour_in),
    .digit_vld   (digit_vld),
    .row         (row),
    .colr        (colr),
    .colg        (colg),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] glyph(input int d, input int r);
    logic [63:0] g;
    case (d)
      0: g = 64'h3C666E7666663C00;
      1: g = 64'h1838181818187E00;
      2: g = 64'h3C66060C30607E00;
      3: g = 64'h3C66061C06663C00;
      4: g = 64'h0C1C3C6C7E0C0C00;
      5: g = 64'h7E607C0606663C00;
      6: g = 64'h3C607C6666663C00;
      7: g = 64'h7E060C1830303000;
      8: g = 64'h3C66663C66663C00;
      9: g = 64'h3C66663E060C3800;
      default: g = 64'h0;
    endcase
    return g[(7-r)*8 +: 8];
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input logic [3:0] d, input logic [1:0] c);
    digit_in  = d;
    colour_in = c;
    digit_vld = 1'b1;
    step(1);
    digit_vld = 1'b0;
  endtask

  task automatic wait_frame(input string tag);
    int n = 0;
    while (frame_start !== 1'b1 && n < 100) begin
      step(1);
      n++;
    end
    chk({tag, "_frame_start"}, {7'd0, frame_start}, 8'h01);
  endtask

  // Checks one full frame; returns at the first negedge of the next frame.
  task automatic check_frame(input string tag, input int d, input logic [1:0] c, input bit blank);
    logic [7:0] er;
    logic [7:0] pr;
    logic [7:0] pg;
    wait_frame(tag);
    for (int r = 0; r < 8; r++) begin
      er = 8'b1 << r;
      er = ~er;
      pr = (c[0] && !blank) ? glyph(d, r) : 8'h00;
      pg = (c[1] && !blank) ? glyph(d, r) : 8'h00;
      chk($sformatf("%s_row%0d", tag, r), row, er);
      chk($sformatf("%s_colr%0d", tag, r), colr, pr);
      chk($sformatf("%s_colg%0d", tag, r), colg, pg);
      if (r == 0) begin
        step(1);
        chk({tag, "_fs_pulse"}, {7'd0, frame_start}, 8'h00);
        step(3);
      end else begin
        step(4);
      end
    end
  endtask

  initial begin
`ifdef DZ_SCAN_BLINK_EN
    blink_en = 1'b1;
`else
    blink_en = 1'b0;
`endif
    // 1. reset, then idle scan showing digit 0 with colour off
    step(3);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_pre_row%0d", i), row, 8'hFF);
      chk($sformatf("t1_pre_colr%0d", i), colr, 8'h00);
      step(1);
    end
    check_frame("t1", 0, 2'b00, 1'b0);

    // 2. mid-frame strobe waits for the next frame
    step(12);
    chk("t2_row3", row, 8'hF7);
    strobe(4'd5, 2'b01);
    step(3);
    for (int r = 4; r < 8; r++) begin
      chk($sformatf("t2_hold_colr%0d", r), colr, 8'h00);
      step(4);
    end
    check_frame("t2", 5, 2'b01, 1'b0);

    // 3. strobe on the frame-boundary tick bypasses the shadow
    step(28);
    chk("t3_row7", row, 8'h7F);
    step(3);
    strobe(4'd8, 2'b11);
    check_frame("t3", 8, 2'b11, 1'b0);

    // 4. two strobes in one frame: last one wins
    step(8);
    strobe(4'd3, 2'b10);
    step(7);
    strobe(4'd7, 2'b10);
    check_frame("t4", 7, 2'b10, 1'b0);

    // 5. non-digit renders blank while rows scan; then reset mid-row
    strobe(4'd12, 2'b11);
    check_frame("t5a", 12, 2'b11, 1'b0);
    check_frame("t5b", 12, 2'b11, 1'b0);
    strobe(4'd8, 2'b11);
    check_frame("t5c", 8, 2'b11, 1'b0);
    step(5);
    chk("t5_pre_rst_colr", colr, 8'h66);
    #2 rst = 1'b0;
    #1;
    chk("t5_rst_row", row, 8'hFF);
    chk("t5_rst_colr", colr, 8'h00);
    chk("t5_rst_colg", colg, 8'h00);
    chk("t5_rst_fs", {7'd0, frame_start}, 8'h00);
    step(3);
    rst = 1'b1;

    // 6. digit 0 in red: steady, or blinking every 2 frames
    strobe(4'd0, 2'b01);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t6_pre_row%0d", i), row, 8'hFF);
      step(1);
    end
    for (int k = 1; k <= 6; k++) begin
      check_frame($sformatf("t6_f%0d", k), 0, 2'b01, blink_en && (((k - 1) % 4) >= 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
